// File: rtl/proc_tx_pkg.sv
// ============================================================================
// Module      : proc_tx_pkg
// Description : Shared definitions for the processor-result UART transmitter.
//               Holds the record layout, the header nibble, the number of
//               bytes per record, the serializer state encoding and a helper
//               that selects one byte out of a record.
// Config      : PROC_TX_PARITY_EN adds the PARITY serializer state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_tx_pkg;

  localparam logic [3:0] HDR_NIBBLE    = 4'hA;
  localparam int         BYTES_PER_REC = 3;
  localparam int         REC_W         = 20;

  // Record field layout: bit 19 = halt, 18 = I, 17 = Z, 16 = S, 15:0 = out.
  typedef struct packed {
    logic        halt;
    logic        i;
    logic        z;
    logic        s;
    logic [15:0] out;
  } rec_t;

`ifdef PROC_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;
`endif

  // Byte 0 is the header {A, halt, I, Z, S}, then out[15:8], then out[7:0].
  function automatic logic [7:0] rec_byte(input rec_t rec, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {HDR_NIBBLE, rec.halt, rec.i, rec.z, rec.s};
      2'd1:    b = rec.out[15:8];
      default: b = rec.out[7:0];
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/proc_tx_fifo.sv
// ============================================================================
// Module      : proc_tx_fifo
// Description : Synchronous record FIFO with full/empty flags. The head entry
//               is presented combinationally on o_rdata. When full, a push is
//               still accepted if a pop happens on the same edge.
// Ports       : clk, rst_n (async, active-low), i_push, i_pop, i_wdata,
//               o_rdata, o_full, o_empty
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_tx_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int           AW     = $clog2(DEPTH);
  localparam logic [AW:0]  C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == C_FULL);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/proc_out_uart_tx.sv
// ============================================================================
// Module      : proc_out_uart_tx
// Description : Watches the processor result interface, queues a record for
//               every change of the output word plus one final record when
//               HALT rises, and streams each record as three UART bytes.
// Ports       : clk, reset (async, active-low), out_in[15:0], i_in, z_in,
//               s_in, halt_in -> tx (idle high), busy, overflow (sticky),
//               done (sticky, HALT record fully sent)
// Config      : PROC_TX_PARITY_EN selects 8E1 framing; default is 8N1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_out_uart_tx
  import proc_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] out_in,
  input  logic        i_in,
  input  logic        z_in,
  input  logic        s_in,
  input  logic        halt_in,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic        done
);

  localparam int            CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    C_BYTE_LAST = 2'(BYTES_PER_REC - 1);

  // Capture side
  logic [15:0] r_last_out;
  logic        r_halt_seen;
  logic        w_change;
  logic        w_halt;
  logic        w_push;
  rec_t        w_push_rec;

  // FIFO
  rec_t        w_head;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;

  // Serializer
  tx_state_t     r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [1:0]    r_byte_idx;
  rec_t          r_rec;
  logic [7:0]    r_byte;

  // Once HALT has been recorded nothing else is captured until reset.
  assign w_change   = (out_in != r_last_out) & ~r_halt_seen;
  assign w_halt     = halt_in & ~r_halt_seen;
  assign w_push     = w_change | w_halt;
  assign w_push_rec = {w_halt, i_in, z_in, s_in, out_in};

  assign w_pop = (r_state == ST_IDLE) & ~w_empty;
  assign busy  = (r_state != ST_IDLE) | ~w_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_out  <= '0;
      r_halt_seen <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // last_out tracks the input even when the record is dropped.
      if (w_change) r_last_out <= out_in;
      if (w_halt)   r_halt_seen <= 1'b1;
      if (w_push && w_full && !w_pop) overflow <= 1'b1;
    end
  end

  proc_tx_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_rec),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_rec      <= '0;
      r_byte     <= '0;
      tx         <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (w_pop) begin
            r_rec      <= w_head;
            r_byte     <= rec_byte(w_head, 2'd0);
            r_byte_idx <= 2'd0;
            r_clk_cnt  <= '0;
            tx         <= 1'b0;
            r_state    <= ST_START;
          end
        end

        ST_START: begin
          if (r_clk_cnt == C_BIT_LAST) begin
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
            tx        <= r_byte[0];
            r_state   <= ST_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (r_clk_cnt == C_BIT_LAST) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef PROC_TX_PARITY_EN
              tx      <= ^r_byte;
              r_state <= ST_PARITY;
`else
              tx      <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              tx        <= r_byte[r_bit_idx + 3'd1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

`ifdef PROC_TX_PARITY_EN
        ST_PARITY: begin
          if (r_clk_cnt == C_BIT_LAST) begin
            r_clk_cnt <= '0;
            tx        <= 1'b1;
            r_state   <= ST_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (r_clk_cnt == C_BIT_LAST) begin
            r_clk_cnt <= '0;
            if (r_byte_idx != C_BYTE_LAST) begin
              // Next byte of the same record follows with no idle gap.
              r_byte_idx <= r_byte_idx + 2'd1;
              r_byte     <= rec_byte(r_rec, r_byte_idx + 2'd1);
              tx         <= 1'b0;
              r_state    <= ST_START;
            end else begin
              if (r_rec.halt) done <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        default: begin
          tx      <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_proc_out_uart_tx.sv
// ============================================================================
// Module      : tb_proc_out_uart_tx
// Description : Self-checking bench for proc_out_uart_tx. Expected UART bytes
//               are queued as stimulus is applied; a serial monitor decodes
//               tx and compares every byte against the queue head.
// Config      : PROC_TX_PARITY_EN selects 8E1 decoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_out_uart_tx;

  localparam int CPB = 4;
  localparam int DEPTH = 8;
`ifdef PROC_TX_PARITY_EN
  localparam int BITS_PER_BYTE = 11;
`else
  localparam int BITS_PER_BYTE = 10;
`endif
  localparam int REC_CLKS = 3 * BITS_PER_BYTE * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] out_in = 16'h0000;
  logic        i_in = 1'b0;
  logic        z_in = 1'b0;
  logic        s_in = 1'b0;
  logic        halt_in = 1'b0;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic        done;

  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  int         n_starts = 0;
  int         first_start_cyc = -1;
  logic [7:0] sb_q[$];

  proc_out_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .out_in   (out_in),
    .i_in     (i_in),
    .z_in     (z_in),
    .s_in     (s_in),
    .halt_in  (halt_in),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_rec(input logic h, input logic i, input logic z, input logic s,
                          input logic [15:0] v);
    sb_q.push_back({4'hA, h, i, z, s});
    sb_q.push_back(v[15:8]);
    sb_q.push_back(v[7:0]);
  endtask

  task automatic wait_idle(input int max_cyc, output int end_cyc);
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) check("idle_timeout", {31'd0, busy}, 32'd0);
    end_cyc = cyc;
  endtask

  // Serial monitor: samples every bit near its centre on falling clock edges.
  initial begin : mon
    logic [7:0] rx;
    logic       abort;
    logic       bit_v;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        n_starts++;
        if (first_start_cyc < 0) first_start_cyc = cyc;
        abort = 1'b0;
        repeat (CPB/2) @(negedge clk);
        if (reset !== 1'b1) abort = 1'b1;
        bit_v = tx;
        if (!abort) check("start_bit", {31'd0, bit_v}, 32'd0);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          if (reset !== 1'b1) abort = 1'b1;
          rx[b] = tx;
        end
`ifdef PROC_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        if (reset !== 1'b1) abort = 1'b1;
        bit_v = tx;
        if (!abort) check("parity_bit", {31'd0, bit_v}, {31'd0, ^rx});
`endif
        repeat (CPB) @(negedge clk);
        if (reset !== 1'b1) abort = 1'b1;
        bit_v = tx;
        if (!abort) begin
          check("stop_bit", {31'd0, bit_v}, 32'd1);
          check("sb_has_entry", {31'd0, (sb_q.size() != 0)}, 32'd1);
          if (sb_q.size() != 0) check("rx_byte", {24'd0, rx}, {24'd0, sb_q.pop_front()});
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: observed no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int c0;
    int end_c;
    int ns0;

    // ---------------- reset ----------------
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_held", {31'd0, tx}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // ---------------- single record 0x1234, I=1 ----------------
    first_start_cyc = -1;
    out_in = 16'h1234; i_in = 1'b1;
    push_rec(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
    @(posedge clk); #1 c0 = cyc;
    wait_idle(1000, end_c);
    check("rec_start_latency", first_start_cyc, c0 + 1);
    check("rec_busy_end", end_c, c0 + 1 + REC_CLKS);
    check("rec_sb_empty", sb_q.size(), 0);

    // ---------------- held value: exactly one record ----------------
    @(negedge clk);
    ns0 = n_starts;
    out_in = 16'h5555; i_in = 1'b0; s_in = 1'b1;
    push_rec(1'b0, 1'b0, 1'b0, 1'b1, 16'h5555);
    @(posedge clk);
    wait_idle(1000, end_c);
    repeat (50) @(negedge clk);
    check("hold_one_record", n_starts - ns0, 3);
    check("hold_busy", {31'd0, busy}, 32'd0);
    check("hold_sb_empty", sb_q.size(), 0);

    // ---------------- overflow: 11 changes on consecutive edges ----------------
    ns0 = n_starts;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9)  check("ovf_before_E9", {31'd0, overflow}, 32'd0);
      if (k == 10) check("ovf_at_E9", {31'd0, overflow}, 32'd1);
      out_in = 16'h1000 + 16'(k);
      z_in = 1'b1; s_in = 1'b1;
      if (k <= 8) push_rec(1'b0, 1'b0, 1'b1, 1'b1, 16'h1000 + 16'(k));
    end
    @(posedge clk);
    wait_idle(3000, end_c);
    check("ovf_records", n_starts - ns0, 27);
    check("ovf_sb_empty", sb_q.size(), 0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // ---------------- reset mid-frame ----------------
    @(negedge clk);
    out_in = 16'h00FF; z_in = 1'b0; s_in = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0; out_in = 16'h0000;
    #1 check("mid_tx_async", {31'd0, tx}, 32'd1);
    check("mid_busy_async", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_overflow_clr", {31'd0, overflow}, 32'd0);
    check("mid_done_clr", {31'd0, done}, 32'd0);
    ns0 = n_starts;
    repeat (200) @(negedge clk);
    check("mid_no_resume", n_starts, ns0);
    check("mid_busy_after", {31'd0, busy}, 32'd0);

    // ---------------- HALT record ----------------
    out_in = 16'h00FF;
    push_rec(1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF);
    @(posedge clk); #1 c0 = cyc;
    @(negedge clk);
    halt_in = 1'b1;
    push_rec(1'b1, 1'b0, 1'b0, 1'b0, 16'h00FF);
    @(negedge clk);
    check("halt_done_early", {31'd0, done}, 32'd0);
    wait_idle(2000, end_c);
    check("halt_end_cycle", end_c, c0 + 1 + 2 * REC_CLKS + 1);
    check("halt_done", {31'd0, done}, 32'd1);
    check("halt_sb_empty", sb_q.size(), 0);
    ns0 = n_starts;
    out_in = 16'h1111;
    @(negedge clk);
    out_in = 16'h2222; halt_in = 1'b0;
    repeat (300) @(negedge clk);
    check("halt_ignored", n_starts, ns0);
    check("halt_busy_after", {31'd0, busy}, 32'd0);
    check("halt_done_sticky", {31'd0, done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/proc_out_uart_tx.md
Name: proc_out_uart_tx

Overview:
Receiving end of the processor's result interface (out[15:0], I, Z, S, HALT).
- Watches the processor outputs every clock.
- Queues a record each time the output word changes, plus one final record when HALT rises.
- Streams each record as a 3-byte 8N1 UART frame.
- Sits beside `processor` at top level so results leave the FPGA without a simulator.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); minimum 2.
- FIFO_DEPTH, 8, record FIFO entries (power of 2).

Ports:
- clk  in  1  system clock, shared with processor.
- reset  in  1  asynchronous, active-low reset.
- out_in  in  16  processor `out` bus.
- i_in  in  1  processor I flag.
- z_in  in  1  processor Z flag.
- s_in  in  1  processor S flag.
- halt_in  in  1  processor HALT.
- tx  out  1  UART serial line, idle high.
- busy  out  1  serializer not idle, or FIFO not empty.
- overflow  out  1  sticky: a record was dropped because the FIFO was full.
- done  out  1  sticky: HALT record fully transmitted.

Behaviour:
- Reset (asynchronous, reset=0): tx=1, busy=0, overflow=0, done=0; last_out=0, halt_seen=0, FIFO empty, FSM=IDLE. Takes effect immediately, including mid-bit; nothing resumes after release.
- Capture, at each rising edge while halt_seen=0:
  - if out_in != last_out, push {0,i_in,z_in,s_in,out_in} and set last_out=out_in;
  - if halt_in=1, push {1,i_in,z_in,s_in,out_in} and set halt_seen=1;
  - change and HALT on the same edge produce a single record, with the halt bit set.
- After halt_seen=1, all inputs are ignored until reset.
- FIFO full: the push is dropped, overflow=1, and last_out still updates. A push and a pop on the same edge while full succeed.
- Record byte order:
  - header = {4'hA, halt, I, Z, S};
  - then out[15:8];
  - then out[7:0].
- Each byte: start bit 0, 8 data bits LSB first, stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE & FIFO not empty: pop, load byte 0, go to START. tx is registered and goes low after this edge.
  - START: after CLKS_PER_BIT cycles go to DATA, bit index 0.
  - DATA: after CLKS_PER_BIT cycles per bit, through bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, if byte index < 2, load the next byte and go to START (no gap); otherwise go to IDLE.
- Latency: change sampled at edge E0, pop at E1, start bit begins at E1. Consecutive records are separated by exactly 1 idle clock.
- done: set on the edge the FSM leaves STOP of the halt record.
- busy: combinational OR of (FSM != IDLE) and (FIFO not empty).

Optional Feature:
- Macro: PROC_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP carrying even parity of the 8 data bits (8E1, 11 bits per byte).
- Undefined: 8N1 as above, and the PARITY state does not exist.

Decomposition:
- Shared package proc_tx_pkg holds:
  - HDR_NIBBLE = 4'hA;
  - BYTES_PER_REC = 3;
  - FSM state encodings;
  - the record field layout (bit 19 = halt, 18 = I, 17 = Z, 16 = S, 15:0 = out).
- One sub-module, proc_tx_fifo: a synchronous 20-bit FIFO with full/empty flags and FIFO_DEPTH as a parameter.

Test Plan (CLKS_PER_BIT=4):
- Hold reset=0 for 3 cycles, then release -> tx=1, busy=0, overflow=0, done=0; then assert reset mid-frame -> tx=1 in the same time step, and no further start bits after release.
- out_in 0x0000->0x1234, I=1, Z=0, S=0 -> tx carries bytes 0xA4, 0x12, 0x34; first start bit low from E1; 120 clocks total.
- out_in=0x00FF, then halt_in rises with I=Z=S=0 -> record 0xA8, 0x00, 0xFF; done=1 after its last stop bit; later out_in changes produce no tx activity.
- Distinct out_in values on 11 consecutive edges E0..E10 -> 9 records transmitted in order; overflow=1 from E9 onward.
- Same value on out_in for 50 cycles after one change -> exactly one record, busy=0 afterwards.
- With PROC_TX_PARITY_EN, record 0x1234 I=1 -> parity bits 1 (0xA4), 0 (0x12), 1 (0x34); 11 bit times per byte.
